// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: registers MEM-stage control alongside the data
// memory's synchronous read, selects load data or ALU result for write-back,
// keeps a copy of load data across write-back stalls, and counts retired
// instructions and loads for debug.
module mem_wb_stage #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              MemValid,
  input  logic              MemRegWrite,
  input  logic              MemMemToReg,
  input  logic [REG_AW-1:0] MemWriteReg,
  input  logic [DATA_W-1:0] MemALUResult,
  input  logic [DATA_W-1:0] ReadData,
  input  logic              Stall,
  input  logic              Flush,
  output logic              WBValid,
  output logic              WBRegWrite,
  output logic [REG_AW-1:0] WBWriteReg,
  output logic [DATA_W-1:0] WBWriteData,
  output logic [CNT_W-1:0]  RetireCount,
  output logic [CNT_W-1:0]  LoadCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              r_wb_valid;
  logic              r_wb_regwrite;
  logic              r_wb_memtoreg;
  logic [REG_AW-1:0] r_wb_reg;
  logic [DATA_W-1:0] r_wb_alu;
  logic              r_hold_valid;
  logic [DATA_W-1:0] r_hold_data;
  logic [CNT_W-1:0]  r_retire_cnt;
  logic [CNT_W-1:0]  r_load_cnt;

  logic              w_cap_valid;
  logic              w_retire;
  logic              w_hold_load;
  logic [DATA_W-1:0] w_load_data;

  assign w_cap_valid = MemValid & ~Flush;
  assign w_retire    = r_wb_valid & ~Stall;
  // Only the first stalled edge samples ReadData; the memory keeps re-reading
  // the moving MEM address afterwards, so later values are not this load's.
  assign w_hold_load = Stall & ~r_hold_valid & r_wb_valid & r_wb_memtoreg;

  // WB entry: capture from MEM when not stalled, otherwise freeze (Flush ignored)
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wb_valid    <= 1'b0;
      r_wb_regwrite <= 1'b0;
      r_wb_memtoreg <= 1'b0;
      r_wb_reg      <= '0;
      r_wb_alu      <= '0;
    end else if (!Stall) begin
      r_wb_valid    <= w_cap_valid;
      r_wb_regwrite <= w_cap_valid & MemRegWrite;
      r_wb_memtoreg <= w_cap_valid & MemMemToReg;
      r_wb_reg      <= MemWriteReg;
      r_wb_alu      <= MemALUResult;
    end
  end

  // Load hold: latch ReadData on the first stalled edge, drop it on capture
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else if (!Stall) begin
      r_hold_valid <= 1'b0;
    end else if (w_hold_load) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= ReadData;
    end
  end

  // Saturating retire and load counters, stepped when a valid entry leaves WB
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_retire_cnt <= '0;
      r_load_cnt   <= '0;
    end else if (w_retire) begin
      if (r_retire_cnt != CNT_MAX) r_retire_cnt <= r_retire_cnt + CNT_ONE;
      if (r_wb_memtoreg && (r_load_cnt != CNT_MAX)) r_load_cnt <= r_load_cnt + CNT_ONE;
    end
  end

  assign w_load_data = r_hold_valid ? r_hold_data : ReadData;

  assign WBValid     = r_wb_valid;
  assign WBRegWrite  = r_wb_valid & r_wb_regwrite & ~Stall;
  assign WBWriteReg  = r_wb_reg;
  assign WBWriteData = r_wb_memtoreg ? w_load_data : r_wb_alu;
  assign RetireCount = r_retire_cnt;
  assign LoadCount   = r_load_cnt;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table plus hand-written sequences
// for stall hold, stall/flush priority, reset during stall and saturation.
module tb_mem_wb_stage;

  logic       CLK;
  logic       RST_N;
  logic       MemValid, MemRegWrite, MemMemToReg;
  logic [2:0] MemWriteReg;
  logic [7:0] MemALUResult;
  logic [7:0] ReadData;
  logic       Stall, Flush;

  logic        WBValid, WBRegWrite;
  logic [2:0]  WBWriteReg;
  logic [7:0]  WBWriteData;
  logic [15:0] RetireCount, LoadCount;

  logic        WBValid4, WBRegWrite4;
  logic [2:0]  WBWriteReg4;
  logic [7:0]  WBWriteData4;
  logic [3:0]  RetireCount4, LoadCount4;

  int n_cmp = 0;
  int n_bad = 0;

  mem_wb_stage dut (
    .CLK(CLK), .RST_N(RST_N), .MemValid(MemValid), .MemRegWrite(MemRegWrite),
    .MemMemToReg(MemMemToReg), .MemWriteReg(MemWriteReg), .MemALUResult(MemALUResult),
    .ReadData(ReadData), .Stall(Stall), .Flush(Flush), .WBValid(WBValid),
    .WBRegWrite(WBRegWrite), .WBWriteReg(WBWriteReg), .WBWriteData(WBWriteData),
    .RetireCount(RetireCount), .LoadCount(LoadCount)
  );

  mem_wb_stage #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .MemValid(MemValid), .MemRegWrite(MemRegWrite),
    .MemMemToReg(MemMemToReg), .MemWriteReg(MemWriteReg), .MemALUResult(MemALUResult),
    .ReadData(ReadData), .Stall(Stall), .Flush(Flush), .WBValid(WBValid4),
    .WBRegWrite(WBRegWrite4), .WBWriteReg(WBWriteReg4), .WBWriteData(WBWriteData4),
    .RetireCount(RetireCount4), .LoadCount(LoadCount4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Data memory model: Memory[i] = i, synchronous read addressed by the ALU result
  logic [7:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i[7:0];
    ReadData = 8'h00;
  end
  always @(posedge CLK) ReadData <= mem[MemALUResult];

  typedef struct {
    int v, rw, m2r, rg, alu, fl;
    int e_v, e_rw, e_rg, e_d, e_ret, e_ld;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drv(input int v, input int rw, input int m2r, input int rg,
                     input int alu, input int st, input int fl);
    MemValid     = v[0];
    MemRegWrite  = rw[0];
    MemMemToReg  = m2r[0];
    MemWriteReg  = rg[2:0];
    MemALUResult = alu[7:0];
    Stall        = st[0];
    Flush        = fl[0];
  endtask

  task automatic chk_wb(input string nm, input int v, input int rw, input int rg, input int d);
    chk({nm, ".valid"}, int'(WBValid), v);
    chk({nm, ".regwrite"}, int'(WBRegWrite), rw);
    chk({nm, ".reg"}, int'(WBWriteReg), rg);
    chk({nm, ".data"}, int'(WBWriteData), d);
  endtask

  task automatic chk_cnt(input string nm, input int ret, input int ld);
    chk({nm, ".retire"}, int'(RetireCount), ret);
    chk({nm, ".loads"}, int'(LoadCount), ld);
  endtask

  int wr_seen;

  initial begin
    //             v rw m2r rg alu    fl | e_v e_rw e_rg e_d   ret ld
    vecs[0] = '{1, 1, 0, 3, 'h5C, 0,  1, 1, 3, 'h5C, 0, 0};  // ALU op
    vecs[1] = '{1, 1, 1, 5, 'h2A, 0,  1, 1, 5, 'h2A, 1, 0};  // load
    vecs[2] = '{1, 1, 0, 2, 'h33, 1,  0, 0, 2, 'h33, 2, 1};  // flushed ALU
    vecs[3] = '{1, 0, 0, 7, 'h81, 0,  1, 0, 7, 'h81, 2, 1};  // store
    vecs[4] = '{0, 1, 1, 1, 'h44, 0,  0, 0, 1, 'h44, 3, 1};  // invalid slot
    vecs[5] = '{1, 1, 0, 0, 'hFF, 0,  1, 1, 0, 'hFF, 3, 1};  // write to r0
    vecs[6] = '{1, 1, 1, 6, 'h90, 0,  1, 1, 6, 'h90, 4, 1};  // load
    vecs[7] = '{1, 1, 1, 4, 'h12, 1,  0, 0, 4, 'h12, 5, 2};  // flushed load

    RST_N = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk_wb("reset", 0, 0, 0, 0);
    chk_cnt("reset", 0, 0);
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;

    for (int k = 0; k < 8; k++) begin
      drv(vecs[k].v, vecs[k].rw, vecs[k].m2r, vecs[k].rg, vecs[k].alu, 0, vecs[k].fl);
      @(posedge CLK); #1;
      chk_wb($sformatf("vec%0d", k), vecs[k].e_v, vecs[k].e_rw, vecs[k].e_rg, vecs[k].e_d);
      chk_cnt($sformatf("vec%0d", k), vecs[k].e_ret, vecs[k].e_ld);
    end

    // Load to 0x2A, then 3 stalled cycles while MEM address moves to 0x10/0x11
    drv(1, 1, 1, 1, 'h2A, 0, 0);
    @(posedge CLK); #1;
    chk_cnt("pre_stall", 5, 2);
    drv(1, 1, 0, 6, 'h10, 1, 0);
    #1 chk_wb("stall1", 1, 0, 1, 'h2A);
    @(posedge CLK); #1;
    drv(1, 1, 0, 6, 'h11, 1, 1);
    #1 chk_wb("stall2_flush", 1, 0, 1, 'h2A);
    @(posedge CLK); #1;
    drv(1, 1, 0, 6, 'h11, 1, 0);
    #1 chk_wb("stall3", 1, 0, 1, 'h2A);
    chk_cnt("stall3", 5, 2);
    @(posedge CLK); #1;
    drv(0, 0, 0, 0, 'h11, 0, 0);
    #1 chk_wb("stall_release", 1, 1, 1, 'h2A);
    @(posedge CLK); #1;
    chk_wb("after_release", 0, 0, 0, 'h11);
    chk_cnt("after_release", 6, 3);

    // Reset pulsed while holding load data 0x77
    drv(1, 1, 1, 2, 'h77, 0, 0);
    @(posedge CLK); #1;
    drv(1, 1, 0, 6, 'h05, 1, 0);
    @(posedge CLK); #1;
    chk("hold77.data", int'(WBWriteData), 'h77);
    RST_N = 1'b0;
    #1;
    chk_wb("rst_stall", 0, 0, 0, 0);
    chk_cnt("rst_stall", 0, 0);
    chk("rst_stall.retire4", int'(RetireCount4), 0);
    RST_N = 1'b1;
    drv(1, 1, 1, 4, 'h33, 0, 0);
    @(posedge CLK); #1;
    chk_wb("post_rst", 1, 1, 4, 'h33);
    chk_cnt("post_rst", 0, 0);

    // 20 back-to-back loads; the 4-bit counters must stop at 15
    wr_seen = 0;
    for (int i = 0; i < 20; i++) begin
      drv(1, 1, 1, i % 8, 'h40 + i, 0, 0);
      @(posedge CLK); #1;
      if (WBRegWrite && WBWriteData == 8'(8'h40 + i)) wr_seen++;
    end
    chk("b2b.writes", wr_seen, 20);
    drv(0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK); #1;
    chk_cnt("b2b", 21, 21);
    chk("sat.retire4", int'(RetireCount4), 15);
    chk("sat.loads4", int'(LoadCount4), 15);
    @(posedge CLK); #1;
    chk("sat_hold.retire4", int'(RetireCount4), 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline stage of the 8-bit pipelined core, directly downstream of the data memory. It registers the MEM-stage control and ALU result in step with the data memory's synchronous read. It selects load data or ALU result for register-file write-back and keeps a held copy of load data across write-back stalls. It also keeps saturating retired-instruction and load counters for debug.

## Interface
Parameters:
- DATA_W, 8, data/ALU width
- REG_AW, 3, register-file address width
- CNT_W, 16, width of each performance counter

Ports:
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous active-low reset
- MemValid  in  1  MEM-stage slot holds a real instruction
- MemRegWrite  in  1  instruction writes the register file
- MemMemToReg  in  1  1 = load (write-back data from memory), 0 = ALU result
- MemWriteReg  in  REG_AW  destination register
- MemALUResult  in  DATA_W  ALU result; the same value drives the data-memory address
- ReadData  in  DATA_W  data-memory read port; valid the cycle after the address was clocked
- Stall  in  1  hold the WB entry; nothing retires
- Flush  in  1  squash the instruction being captured from MEM
- WBValid  out  1  WB entry valid
- WBRegWrite  out  1  register-file write enable, exactly one cycle per retiring writer
- WBWriteReg  out  REG_AW  register-file write address
- WBWriteData  out  DATA_W  register-file write data, also the forwarding source
- RetireCount  out  CNT_W  instructions retired, saturating
- LoadCount  out  CNT_W  loads retired, saturating

## Operation
State:
- WB entry: wb_valid, wb_regwrite, wb_memtoreg, wb_reg, wb_alu.
- Load hold: hold_valid, hold_data.
- Two counters.

Capture, at the rising edge with Stall=0:
- Load the WB entry from the Mem* inputs.
- wb_valid <= MemValid & ~Flush.
- When the captured slot is invalid, clear wb_regwrite and wb_memtoreg.
- hold_valid <= 0.

Stall=1, at the rising edge:
- The WB entry holds.
- Flush is ignored; upstream re-asserts it once the stall clears.
- If hold_valid=0 and wb_valid & wb_memtoreg, then hold_data <= ReadData and hold_valid <= 1.
- This preserves load data, because the data memory re-reads on every edge and ReadData may change while WB is frozen.

Write-back select (combinational):
- WBWriteData = wb_memtoreg ? (hold_valid ? hold_data : ReadData) : wb_alu.
- WBRegWrite = wb_valid & wb_regwrite & ~Stall.
- WBValid = wb_valid.
- WBWriteReg = wb_reg.

Counters, at the rising edge when wb_valid & ~Stall:
- RetireCount increments.
- LoadCount also increments if wb_memtoreg.
- Both saturate at all-ones and never wrap.
- Stores and invalid slots count in RetireCount only if valid; stores are valid, non-load.

Register 0 is an ordinary register; no write suppression.

## Timing
- Reset (async, RST_N=0): all state cleared, hold_valid=0, counters 0. Outputs: WBValid=0, WBRegWrite=0, WBWriteReg=0, WBWriteData=0, RetireCount=0, LoadCount=0.
- Reset asserted mid-stall discards the held data. The first edge after release behaves as a normal capture.
- Latency: an instruction in MEM during cycle n is in WB during cycle n+1.
  - Load data arrives on ReadData in cycle n+1, same cycle as WB.
  - Register-file write occurs at the end of the first non-stalled WB cycle.
- The stall hold edge is the first stalled edge. Later stalled edges do not overwrite hold_data.
- Stall and Flush both high: stall wins; the entry holds and is not squashed.
- Flush with MemValid=1 and Stall=0: a bubble enters WB, with WBRegWrite=0 and no count.
- Back-to-back non-stalled instructions retire one per cycle. No bubbles are inserted by this block.

## Test plan
- ALU op: MemValid=1, MemRegWrite=1, MemMemToReg=0, MemWriteReg=3, MemALUResult=0x5C -> next cycle WBRegWrite=1, WBWriteReg=3, WBWriteData=0x5C; RetireCount=1.
- Load, no stall, memory initialised Memory[i]=i, address 0x2A -> next cycle WBWriteData=0x2A, WBRegWrite=1; LoadCount=1.
- Load to addr 0x2A, then Stall=1 for 3 cycles while the MEM address moves to 0x10 and 0x11 -> WBWriteData stays 0x2A and WBRegWrite stays 0 during the stall. After Stall drops: one write of 0x2A, RetireCount+1.
- Flush=1 on a valid ALU op -> WBValid=0, no write, counters unchanged. Stall=1 together with Flush=1 -> the previous entry holds unchanged.
- CNT_W=4, 20 back-to-back loads -> RetireCount and LoadCount stop at 15.
- RST_N pulsed low during a stall holding load data 0x77 -> all outputs 0 immediately. Next non-stalled capture behaves normally, with no trace of 0x77.
